// File: rtl/lsu.sv
// Load/store unit: one outstanding data-bus access per instruction, stalling the
// pipeline through hold_flag_o until the access completes or is abandoned.
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        hold_flag_o,
    output logic        reg_wen_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  size_q, size_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic        we_q, we_d;
    logic        kill_q, kill_d;
    logic        reg_wen_q, reg_wen_d;
    logic        err_q, err_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic        start;
    logic        type_ok;
    logic        align_ok;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign start = (mem_re_i | mem_we_i) & ~flush_i;

    always_comb begin
        type_ok  = 1'b0;
        align_ok = 1'b0;
        case (mem_size_i)
            3'b000, 3'b100: begin
                type_ok  = 1'b1;
                align_ok = 1'b1;
            end
            3'b001, 3'b101: begin
                type_ok  = 1'b1;
                align_ok = ~mem_addr_i[0];
            end
            3'b010: begin
                type_ok  = 1'b1;
                align_ok = (mem_addr_i[1:0] == 2'b00);
            end
            default: ;
        endcase
        // Unsigned stores do not exist, and a simultaneous load+store is malformed.
        if (mem_we_i && mem_size_i[2]) type_ok = 1'b0;
        if (mem_re_i && mem_we_i)      type_ok = 1'b0;
    end

    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = bus_rdata_i[7:0];
            2'b01:   ld_byte = bus_rdata_i[15:8];
            2'b10:   ld_byte = bus_rdata_i[23:16];
            default: ld_byte = bus_rdata_i[31:24];
        endcase
        ld_half = addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (size_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'b0, ld_byte};
            3'b101:  ld_ext = {16'b0, ld_half};
            default: ld_ext = bus_rdata_i;
        endcase
    end

    always_comb begin
        case (size_q[1:0])
            2'b00: begin
                bus_be_o    = 4'b0001 << addr_q[1:0];
                bus_wdata_o = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                bus_be_o    = addr_q[1] ? 4'b1100 : 4'b0011;
                bus_wdata_o = {2{wdata_q[15:0]}};
            end
            default: begin
                bus_be_o    = 4'b1111;
                bus_wdata_o = wdata_q;
            end
        endcase
    end

    assign bus_addr_o = {addr_q[31:2], 2'b00};
    assign bus_we_o   = we_q & (state_q == S_REQ);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        ld_rd_d     = ld_rd_q;
        we_d        = we_q;
        kill_d      = kill_q;
        reg_wen_d   = 1'b0;
        err_d       = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        hold_flag_o = 1'b0;
        bus_req_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hold_flag_o = 1'b1;
                    addr_d      = mem_addr_i;
                    wdata_d     = mem_wdata_i;
                    size_d      = mem_size_i;
                    ld_rd_d     = rd_addr_i;
                    we_d        = mem_we_i;
                    kill_d      = 1'b0;
                    if (type_ok && align_ok) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_REQ: begin
                hold_flag_o = 1'b1;
                bus_req_o   = 1'b1;
                // Once granted the access cannot be recalled; a flush only squashes writeback.
                if (bus_gnt_i) begin
                    kill_d  = flush_i;
                    state_d = we_q ? S_DONE : S_RESP;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                hold_flag_o = 1'b1;
                if (flush_i) kill_d = 1'b1;
                if (bus_rvalid_i) begin
                    state_d   = S_DONE;
                    reg_wen_d = ~kill_q & ~flush_i;
                    rd_data_d = ld_ext;
                    rd_addr_d = ld_rd_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            ld_rd_q   <= '0;
            we_q      <= 1'b0;
            kill_q    <= 1'b0;
            reg_wen_q <= 1'b0;
            err_q     <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            ld_rd_q   <= ld_rd_d;
            we_q      <= we_d;
            kill_q    <= kill_d;
            reg_wen_q <= reg_wen_d;
            err_q     <= err_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign reg_wen_o = reg_wen_q;
    assign err_o     = err_q;
    assign rd_addr_o = rd_addr_q;
    assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: the driver plays pipeline and bus slave and queues
// expected bus beats and writebacks; a negedge monitor checks what the DUT shows.
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        mem_re_i, mem_we_i;
    logic [2:0]  mem_size_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        hold_flag_o, reg_wen_o, err_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    lsu dut (
        .clk(clk), .rst(rst),
        .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .rd_addr_i(rd_addr_i),
        .flush_i(flush_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .hold_flag_o(hold_flag_o), .reg_wen_o(reg_wen_o), .rd_addr_o(rd_addr_o),
        .rd_data_o(rd_data_o), .err_o(err_o)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cyc;
        int          run;
    } bus_t;

    typedef struct {
        bit          err;
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } res_t;

    bus_t bus_q[$];
    res_t res_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    bit   chk_en = 0;
    bit   chk_hold = 1;
    bit   hold_exp = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference rules: what is a legal access, what the bus should see, what a load returns.
    function automatic bit legal(bit re, bit we, logic [2:0] sz, logic [31:0] a);
        if (re && we) return 1'b0;
        if (we && sz > 3'd3) return 1'b0;
        case (sz)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (a % 2) == 0;
            3'd2:       return (a % 4) == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_val(logic [2:0] sz, logic [31:0] a, logic [31:0] word);
        logic [31:0] w;
        w = word >> (8 * (a % 4));
        case (sz)
            3'd0:    return 32'(int'($signed(w[7:0])));
            3'd1:    return 32'(int'($signed(w[15:0])));
            3'd4:    return {24'b0, w[7:0]};
            3'd5:    return {16'b0, w[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic bus_t store_beat(bit we, logic [2:0] sz, logic [31:0] a, logic [31:0] wd);
        bus_t b;
        b.we    = we;
        b.addr  = a - (a % 4);
        b.cyc   = 0;
        b.run   = 0;
        case (sz)
            3'd0: begin b.be = 4'(1 << (a % 4)); b.wdata = {4{wd[7:0]}};  end
            3'd1: begin b.be = 4'(3 << (a % 4)); b.wdata = {2{wd[15:0]}}; end
            default: begin b.be = 4'hF; b.wdata = wd; end
        endcase
        return b;
    endfunction

    task automatic idle_inputs();
        mem_re_i = 1'b0;
        mem_we_i = 1'b0;
        flush_i  = 1'b0;
    endtask

    // fl: 0 none, 1 flush at start, 2 flush in REQ before gnt, 3 flush with gnt, 4 flush in RESP
    task automatic do_txn(input bit re, input bit we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input int g, input int r,
                          input logic [31:0] rdat, input int fl);
        int   t0;
        bus_t b;
        res_t e;
        t0 = cyc;
        mem_re_i = re; mem_we_i = we; mem_size_i = sz;
        mem_addr_i = a; mem_wdata_i = wd; rd_addr_i = rd;
        if (fl == 1) begin
            flush_i = 1'b1; hold_exp = 1'b0;
            @(posedge clk); #1; idle_inputs();
            return;
        end
        hold_exp = 1'b1;
        if (!legal(re, we, sz, a)) begin
            e.err = 1'b1; e.rd = rd; e.data = '0; e.cyc = t0 + 1;
            res_q.push_back(e);
            @(posedge clk); #1; idle_inputs(); hold_exp = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1; idle_inputs();
        if (fl == 2) begin
            flush_i = 1'b1;
            @(posedge clk); #1; flush_i = 1'b0; hold_exp = 1'b0;
            return;
        end
        b = store_beat(we, sz, a, wd);
        b.cyc = t0 + 1 + g;
        b.run = g + 1;
        bus_q.push_back(b);
        repeat (g) begin @(posedge clk); #1; end
        bus_gnt_i = 1'b1; flush_i = (fl == 3);
        @(posedge clk); #1; bus_gnt_i = 1'b0; flush_i = 1'b0;
        if (we) begin
            hold_exp = 1'b0;
            @(posedge clk); #1;
            return;
        end
        flush_i = (fl == 4);
        if (fl != 3 && fl != 4) begin
            e.err = 1'b0; e.rd = rd; e.data = load_val(sz, a, rdat); e.cyc = t0 + 3 + g + r;
            res_q.push_back(e);
        end
        repeat (r) begin @(posedge clk); #1; flush_i = 1'b0; end
        bus_rvalid_i = 1'b1; bus_rdata_i = rdat;
        @(posedge clk); #1; bus_rvalid_i = 1'b0; flush_i = 1'b0; bus_rdata_i = $urandom;
        hold_exp = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin : monitor
        int   run;
        bus_t b;
        res_t e;
        run = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (chk_hold) chk("hold_flag", 32'(hold_flag_o), 32'(hold_exp));
                run = bus_req_o ? run + 1 : 0;
                if (bus_req_o && bus_gnt_i) begin
                    if (bus_q.size() == 0) begin
                        chk("bus_unexpected", 32'(bus_q.size()), 32'd1);
                    end else begin
                        b = bus_q.pop_front();
                        chk("bus_we", 32'(bus_we_o), 32'(b.we));
                        chk("bus_addr", bus_addr_o, b.addr);
                        if (b.we) begin
                            chk("bus_be", 32'(bus_be_o), 32'(b.be));
                            chk("bus_wdata", bus_wdata_o, b.wdata);
                        end
                        chk("gnt_cycle", 32'(cyc), 32'(b.cyc));
                        chk("req_held", 32'(run), 32'(b.run));
                    end
                end
                if (reg_wen_o || err_o) begin
                    if (res_q.size() == 0) begin
                        chk("result_unexpected", 32'(res_q.size()), 32'd1);
                    end else begin
                        e = res_q.pop_front();
                        chk("err_o", 32'(err_o), 32'(e.err));
                        chk("reg_wen_o", 32'(reg_wen_o), 32'(!e.err));
                        if (!e.err) begin
                            chk("rd_addr_o", 32'(rd_addr_o), 32'(e.rd));
                            chk("rd_data_o", rd_data_o, e.data);
                        end
                        chk("result_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        end
    end

    initial begin : driver
        int t0;
        bus_t b;
        rst = 1'b1;
        idle_inputs();
        mem_size_i = '0; mem_addr_i = '0; mem_wdata_i = '0; rd_addr_i = '0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_reg_wen", 32'(reg_wen_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_rd_data", rd_data_o, 32'd0);
        chk("rst_rd_addr", 32'(rd_addr_o), 32'd0);
        chk("rst_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst_hold", 32'(hold_flag_o), 32'd0);
        chk_en = 1'b1;
        @(posedge clk); #1;

        // LW, SB with delayed grant, LH/LHU sign vs zero, misaligned LW, flush in RESP
        do_txn(1, 0, 3'b010, 32'h100, 32'h0, 5'd3, 0, 0, 32'h8000_00F0, 0);
        do_txn(0, 1, 3'b000, 32'h203, 32'h0000_00AB, 5'd0, 3, 0, 32'h0, 0);
        do_txn(1, 0, 3'b001, 32'h102, 32'h0, 5'd9, 0, 0, 32'hFFEE_0000, 0);
        do_txn(1, 0, 3'b101, 32'h102, 32'h0, 5'd10, 1, 2, 32'hFFEE_0000, 0);
        do_txn(1, 0, 3'b010, 32'h101, 32'h0, 5'd4, 0, 0, 32'h0, 0);
        do_txn(1, 0, 3'b000, 32'h303, 32'h0, 5'd5, 0, 2, 32'h8100_0000, 4);
        do_txn(1, 0, 3'b100, 32'h303, 32'h0, 5'd6, 0, 0, 32'h8100_0000, 0);

        // reset while waiting for read data; the late rvalid must be ignored
        t0 = cyc;
        mem_re_i = 1'b1; mem_size_i = 3'b010; mem_addr_i = 32'h40; rd_addr_i = 5'd7;
        hold_exp = 1'b1;
        @(posedge clk); #1; idle_inputs();
        b = store_beat(1'b0, 3'b010, 32'h40, 32'h0);
        b.cyc = t0 + 1; b.run = 1;
        bus_q.push_back(b);
        bus_gnt_i = 1'b1;
        @(posedge clk); #1; bus_gnt_i = 1'b0;
        chk_hold = 1'b0; rst = 1'b1; hold_exp = 1'b0;
        @(posedge clk); #1; rst = 1'b0; chk_hold = 1'b1;
        chk("rst_resp_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst_resp_hold", 32'(hold_flag_o), 32'd0);
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
        @(posedge clk); #1; bus_rvalid_i = 1'b0;
        chk("rst_resp_reg_wen", 32'(reg_wen_o), 32'd0);
        @(posedge clk); #1;
        chk("rst_resp_reg_wen2", 32'(reg_wen_o), 32'd0);
        chk("rst_resp_bus_req2", 32'(bus_req_o), 32'd0);

        for (int i = 0; i < 300; i++) begin
            int          k;
            int          fl;
            bit          re, we;
            logic [2:0]  sz;
            logic [31:0] a;
            k  = $urandom_range(0, 15);
            re = (k < 7) || (k == 15);
            we = (k >= 7);
            sz = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            k  = $urandom_range(0, 19);
            fl = (k < 4) ? k + 1 : 0;
            do_txn(re, we, sz, a, $urandom, 5'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom, fl);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        chk("res_q_drained", 32'(res_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
